// File: rtl/register_file_if.sv
// register_file_if: operand/writeback bus of the integer register file.
//   load      - write enable for the write port
//   rd_addr   - destination register index
//   rd_data   - write data
//   rs1_addr  - read port 1 index
//   rs2_addr  - read port 2 index
//   rs1_data  - read port 1 data
//   rs2_data  - read port 2 data
// master drives the write port and the read indices; slave (the register
// file) returns the read data.
interface register_file_if #(
   parameter int unsigned BITS      = 64,
   parameter int unsigned ADDR_BITS = 5
);
   logic                 load;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [BITS-1:0]      rd_data;
   logic [ADDR_BITS-1:0] rs1_addr;
   logic [ADDR_BITS-1:0] rs2_addr;
   logic [BITS-1:0]      rs1_data;
   logic [BITS-1:0]      rs2_data;

   modport master (
      output load, rd_addr, rd_data, rs1_addr, rs2_addr,
      input  rs1_data, rs2_data
   );

   modport slave (
      input  load, rd_addr, rd_data, rs1_addr, rs2_addr,
      output rs1_data, rs2_data
   );
endinterface

// File: rtl/register_file.sv
// register_file: 32-entry RISC-V integer register file, one write port and
// two combinational read ports, x0 hardwired to zero.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears every entry and forces both
//           read ports to zero while asserted
//   bus   - register_file_if slave: write port (load/rd_addr/rd_data) and
//           read ports (rsN_addr -> rsN_data)
// A read that targets the register being written in the same cycle returns
// the incoming write data (write-to-read bypass), never for x0.
module register_file #(
   parameter int unsigned BITS      = 64,
   parameter int unsigned ADDR_BITS = 5
) (
   input logic             clk,
   input logic             reset,
   register_file_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   // Entry 0 exists but is never written, so it holds zero forever.
   logic [BITS-1:0] regs [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.load && (bus.rd_addr != '0)) begin
         regs[bus.rd_addr] <= bus.rd_data;
      end
   end

   // Read path: reset and x0 dominate, then bypass, then stored value.
   always_comb begin
      bus.rs1_data = '0;
      if (!reset && (bus.rs1_addr != '0)) begin
         if (bus.load && (bus.rd_addr == bus.rs1_addr)) begin
            bus.rs1_data = bus.rd_data;
         end else begin
            bus.rs1_data = regs[bus.rs1_addr];
         end
      end
   end

   always_comb begin
      bus.rs2_data = '0;
      if (!reset && (bus.rs2_addr != '0)) begin
         if (bus.load && (bus.rd_addr == bus.rs2_addr)) begin
            bus.rs2_data = bus.rd_data;
         end else begin
            bus.rs2_data = regs[bus.rs2_addr];
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file. The stimulus process
// computes expected read data from an array-based reference model and
// queues it; a monitor process samples the DUT and compares.
module tb_register_file;

   logic clk;
   logic reset;

   register_file_if #(.BITS(64), .ADDR_BITS(5)) bus ();

   register_file #(.BITS(64), .ADDR_BITS(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus shadows
   logic        ld;
   logic [4:0]  rda, a1, a2;
   logic [63:0] rdd;

   assign bus.load     = ld;
   assign bus.rd_addr  = rda;
   assign bus.rd_data  = rdd;
   assign bus.rs1_addr = a1;
   assign bus.rs2_addr = a2;

   // Reference model: architectural register contents
   logic [63:0] model [32];

   typedef struct {
      string       name;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [63:0] e1;
      logic [63:0] e2;
   } exp_t;

   exp_t sb[$];
   event sample_ev;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [63:0] exp_read(input logic [4:0] a);
      if (reset || a == 5'd0) return 64'd0;
      if (ld && rda == a)     return rdd;
      return model[a];
   endfunction

   task automatic check(input string name);
      exp_t e;
      e.name = name;
      e.a1   = a1;
      e.a2   = a2;
      e.e1   = exp_read(a1);
      e.e2   = exp_read(a2);
      sb.push_back(e);
      -> sample_ev;
      #2;
   endtask

   task automatic drive(input logic l, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
      ld  = l;
      rda = wa;
      rdd = wd;
      a1  = r1;
      a2  = r2;
   endtask

   task automatic set_reset(input logic v);
      reset = v;
      if (v) begin
         for (int i = 0; i < 32; i++) model[i] = 64'd0;
      end
   endtask

   // One clock edge; model commits the write, then return at the falling edge.
   task automatic cycle();
      @(posedge clk);
      if (!reset && ld && rda != 5'd0) model[rda] = rdd;
      @(negedge clk);
   endtask

   // Monitor: samples outputs 1 time unit after each request, away from clk edges.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.rs1_data !== e.e1) begin
               n_fail++;
               $display("FAIL %s rs1[%0d]: got %h expected %h", e.name, e.a1, bus.rs1_data, e.e1);
            end
            n_checks++;
            if (bus.rs2_data !== e.e2) begin
               n_fail++;
               $display("FAIL %s rs2[%0d]: got %h expected %h", e.name, e.a2, bus.rs2_data, e.e2);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
      drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
      set_reset(1'b1);
      @(negedge clk);

      // Reset state: everything reads zero, bypass suppressed
      drive(1'b1, 5'd9, 64'hFFFF_0000_FFFF_0000, 5'd9, 5'd31);
      check("reset_read");
      cycle();
      drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
      set_reset(1'b0);
      @(negedge clk);
      for (int i = 0; i < 32; i += 2) begin
         drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(i + 1));
         check("post_reset_zero");
      end

      // Async reset clears state mid-cycle
      drive(1'b1, 5'd5, 64'hDEAD_BEEF_CAFE_F00D, 5'd5, 5'd6);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
      check("x5_written");
      set_reset(1'b1);
      check("async_reset_x5");
      set_reset(1'b0);
      @(negedge clk);

      // Basic write/read
      drive(1'b1, 5'd10, 64'h1234, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 5'd0, 64'd0, 5'd10, 5'd10);
      check("basic_x10");
      drive(1'b0, 5'd0, 64'd0, 5'd11, 5'd9);
      check("basic_others");

      // x0 immutable, bypass on x0 suppressed
      drive(1'b1, 5'd0, '1, 5'd0, 5'd0);
      check("x0_bypass");
      cycle();
      check("x0_after_write");

      // Bypass
      drive(1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd7, 64'h22, 5'd7, 5'd8);
      check("bypass_x7");
      cycle();
      drive(1'b0, 5'd7, 64'h33, 5'd7, 5'd8);
      check("x7_after");

      // load gating
      drive(1'b1, 5'd3, 64'hAA, 5'd0, 5'd0);
      cycle();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 5'd3, 64'hBB, 5'd3, 5'd3);
         check("load_gate_x3");
         cycle();
      end

      // Reset/load collision across an edge
      drive(1'b1, 5'd4, 64'h55, 5'd4, 5'd4);
      set_reset(1'b1);
      check("collide_during");
      cycle();
      drive(1'b0, 5'd0, 64'd0, 5'd4, 5'd4);
      set_reset(1'b0);
      check("collide_x4");

      // Sweep
      for (int i = 1; i < 32; i++) begin
         v = 64'(i) * 64'h0101;
         drive(1'b1, 5'(i), v, 5'd0, 5'd0);
         cycle();
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
         check("sweep");
      end

      // Randomized traffic with occasional async reset pulses
      for (int n = 0; n < 400; n++) begin
         logic [4:0] w;
         w = 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), w, {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)));
         check("random");
         if ($urandom_range(0, 39) == 0) begin
            set_reset(1'b1);
            check("random_reset");
            cycle();
            set_reset(1'b0);
            check("random_release");
         end
         cycle();
      end

      #5;
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry RISC-V integer register file for the multicycle datapath: one write port, two read ports.
- It is the storage-side counterpart of the per-stage pipeline/holding registers. It accepts loads from the writeback path and supplies rs1/rs2 operands to the A/B operand registers.
- x0 is hardwired to zero.
- Write-to-read bypass lets an operand read in the same cycle as its writeback see the new value.

Parameters:
- BITS, 64, data width of every register and of all data ports.
- ADDR_BITS, 5, register index width; depth is 2**ADDR_BITS (32).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; clears all entries
- load  input  1  write enable for the write port
- rd_addr  input  ADDR_BITS  destination register index
- rd_data  input  BITS  write data
- rs1_addr  input  ADDR_BITS  read port 1 index
- rs2_addr  input  ADDR_BITS  read port 2 index
- rs1_data  output  BITS  read port 1 data
- rs2_data  output  BITS  read port 2 data

Behaviour:
- Reset:
  - reset=1 forces every entry 1..31 to 0 immediately, with no clock edge needed.
  - rs1_data and rs2_data read 0 while reset is asserted, regardless of addresses or bypass.
  - On reset deassertion, the first write takes effect on the first rising clk edge at which reset=0 and load=1.
- Write:
  - On posedge clk with reset=0, load=1 and rd_addr!=0, entry[rd_addr] <= rd_data.
  - Writes with rd_addr=0 are discarded.
  - load=0 leaves all entries unchanged.
  - Write latency is 1 cycle: the stored value is visible from the array after that edge.
- Read (combinational, zero latency):
  - rsN_data = 0 if rsN_addr=0.
  - Otherwise, if load=1 and rd_addr=rsN_addr, rsN_data = rd_data (bypass: the value being written this cycle).
  - Otherwise rsN_data = entry[rsN_addr].
- Bypass:
  - Applies to both ports independently.
  - Is never taken for address 0.
  - Is gated by reset (reset=1 means output 0).
- Simultaneous events:
  - Both read ports may address the same register, including the one being written; both return the same value.
  - Reset asserted in the same cycle as a load: reset wins and the entry stays 0.
- Reset mid-operation: asserting reset between clock edges clears state instantly. The next edge performs no write while reset remains high.
- Widths:
  - No arithmetic inside the block.
  - Every index within 0..2**ADDR_BITS-1 is valid; there is no out-of-range case.
  - Data passes through unmodified.
- There are no X outputs after reset for any address.

Test Plan:
- Reset clears state: write 0xDEADBEEF_CAFEF00D to x5, then pulse reset mid-cycle (async) -> rs1_addr=5 reads 0 immediately, before the next clk edge.
- Basic write/read: load=1, rd_addr=10, rd_data=0x0000_0000_0000_1234, clock, load=0 -> rs1_addr=10 and rs2_addr=10 both read 0x1234; other entries remain 0.
- x0 immutable: load=1, rd_addr=0, rd_data=all ones, clock -> rs1_addr=0 reads 0; with load still high and rd_addr=0, the bypass also yields 0.
- Bypass: x7 holds 0x11; load=1, rd_addr=7, rd_data=0x22, rs1_addr=7, rs2_addr=8 before the edge -> rs1_data=0x22 combinationally; after the edge with load=0, rs1_data=0x22.
- load gating: x3=0xAA, then load=0, rd_addr=3, rd_data=0xBB for 3 clocks -> x3 reads 0xAA throughout; no bypass seen.
- Reset vs load collision: reset=1 and load=1, rd_addr=4, rd_data=0x55 across an edge, then release reset -> x4 reads 0.
- Sweep: write index i with value i*0x0101 for i=1..31, then read every pair (i, 31-i) -> each port returns its written value; index 0 returns 0.
